// File: rtl/shared_lifo_controller_if.sv
// Bus bundle between the stack clients, the LIFO controller and the shared RAM.
//
// Client side : full, empty, clear, write_data/valid/ready, pop_valid/ready,
//               response_valid/data/channel
// Memory side : memory_enable, memory_write_enable, memory_address,
//               memory_write_data, memory_read_data (combinational read)
//
// Modports:
//   slave  - the controller (answers client requests, drives the RAM)
//   master - the clients plus the RAM model
interface shared_lifo_controller_if #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
);
  localparam int ADDRESS_WIDTH = $clog2(CHANNELS * DEPTH);
  localparam int CHANNEL_WIDTH = $clog2(CHANNELS);

  logic [CHANNELS-1:0]        full;
  logic [CHANNELS-1:0]        empty;
  logic [CHANNELS-1:0]        clear;
  logic [CHANNELS*WIDTH-1:0]  write_data;
  logic [CHANNELS-1:0]        write_valid;
  logic [CHANNELS-1:0]        write_ready;
  logic [CHANNELS-1:0]        pop_valid;
  logic [CHANNELS-1:0]        pop_ready;
  logic                       response_valid;
  logic [WIDTH-1:0]           response_data;
  logic [CHANNEL_WIDTH-1:0]   response_channel;
  logic                       memory_enable;
  logic                       memory_write_enable;
  logic [ADDRESS_WIDTH-1:0]   memory_address;
  logic [WIDTH-1:0]           memory_write_data;
  logic [WIDTH-1:0]           memory_read_data;

  modport slave (
    input  clear, write_data, write_valid, pop_valid, memory_read_data,
    output full, empty, write_ready, pop_ready,
           response_valid, response_data, response_channel,
           memory_enable, memory_write_enable, memory_address, memory_write_data
  );

  modport master (
    output clear, write_data, write_valid, pop_valid, memory_read_data,
    input  full, empty, write_ready, pop_ready,
           response_valid, response_data, response_channel,
           memory_enable, memory_write_enable, memory_address, memory_write_data
  );
endinterface

// File: rtl/shared_lifo_controller.sv
// Multi-channel LIFO controller. One single-port RAM of CHANNELS*DEPTH words
// is split into CHANNELS stacks of DEPTH words; channel i owns addresses
// [i*DEPTH, i*DEPTH+DEPTH-1]. Requests are arbitrated round-robin, one RAM
// access per cycle; popped words come back one cycle later on a registered
// response port tagged with the channel index.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - client handshakes, status flags, response port and RAM bus
//            (see shared_lifo_controller_if, slave modport)
module shared_lifo_controller #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  shared_lifo_controller_if.slave bus
);
  localparam int ADDRESS_WIDTH = $clog2(CHANNELS * DEPTH);
  localparam int COUNT_WIDTH   = $clog2(DEPTH + 1);
  localparam int CHANNEL_WIDTH = $clog2(CHANNELS);

  localparam logic [COUNT_WIDTH-1:0]   COUNT_FULL   = COUNT_WIDTH'(DEPTH);
  localparam logic [CHANNEL_WIDTH-1:0] CHANNEL_LAST = CHANNEL_WIDTH'(CHANNELS - 1);

  logic [COUNT_WIDTH-1:0]   count [CHANNELS];
  logic [CHANNEL_WIDTH-1:0] pointer;

  logic [CHANNELS-1:0]      empty;
  logic [CHANNELS-1:0]      full;
  logic [CHANNELS-1:0]      eligible;

  logic                     granted;
  logic                     grant_pop;
  logic [CHANNEL_WIDTH-1:0] grant;
  logic [COUNT_WIDTH-1:0]   grant_count;
  logic [WIDTH-1:0]         grant_data;

  logic [CHANNELS-1:0]      push_hit;
  logic [CHANNELS-1:0]      pop_hit;
  logic                     memory_enable;
  logic                     memory_write_enable;
  logic [ADDRESS_WIDTH-1:0] memory_address;
  logic [ADDRESS_WIDTH-1:0] channel_base;
  logic [WIDTH-1:0]         memory_write_data;

  logic                     response_valid;
  logic [WIDTH-1:0]         response_data;
  logic [CHANNEL_WIDTH-1:0] response_channel;

  // Flags decode straight from the registered counts; a cleared channel
  // drops out of arbitration for the cycle in which clear is high.
  always_comb begin
    empty    = '0;
    full     = '0;
    eligible = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      empty[i]    = (count[i] == '0);
      full[i]     = (count[i] == COUNT_FULL);
      eligible[i] = ~bus.clear[i] &
                    ((bus.pop_valid[i] & ~empty[i]) | (bus.write_valid[i] & ~full[i]));
    end
  end

  // Round-robin search starting at the pointer. The wrap is done by a
  // compare-and-subtract so non-power-of-two channel counts work.
  always_comb begin
    int idx;
    idx         = 0;
    granted     = 1'b0;
    grant_pop   = 1'b0;
    grant       = '0;
    grant_count = '0;
    grant_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(pointer) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!granted && eligible[idx]) begin
        granted     = 1'b1;
        grant       = CHANNEL_WIDTH'(idx);
        grant_count = count[idx];
        grant_data  = bus.write_data[idx*WIDTH +: WIDTH];
        // Pop wins over push inside the granted channel.
        grant_pop   = bus.pop_valid[idx] & ~empty[idx];
      end
    end
  end

  // RAM access and handshake decode for the single granted operation.
  always_comb begin
    push_hit            = '0;
    pop_hit             = '0;
    memory_enable       = 1'b0;
    memory_write_enable = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    channel_base        = ADDRESS_WIDTH'(grant) * ADDRESS_WIDTH'(DEPTH);
    if (granted) begin
      memory_enable = 1'b1;
      if (grant_pop) begin
        pop_hit[grant] = 1'b1;
        // Top of stack sits one below the count.
        memory_address = channel_base + ADDRESS_WIDTH'(grant_count) - ADDRESS_WIDTH'(1);
      end else begin
        push_hit[grant]     = 1'b1;
        memory_write_enable = 1'b1;
        memory_address      = channel_base + ADDRESS_WIDTH'(grant_count);
        memory_write_data   = grant_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.clear[i])
          count[i] <= '0;
        else if (push_hit[i])
          count[i] <= count[i] + COUNT_WIDTH'(1);
        else if (pop_hit[i])
          count[i] <= count[i] - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pointer <= '0;
    end else if (granted) begin
      pointer <= (grant == CHANNEL_LAST) ? '0 : grant + CHANNEL_WIDTH'(1);
    end
  end

  // Read data is combinational from the RAM, so it is captured in the same
  // cycle as the pop handshake and presented one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      response_valid   <= 1'b0;
      response_data    <= '0;
      response_channel <= '0;
    end else begin
      response_valid <= granted & grant_pop;
      if (granted && grant_pop) begin
        response_data    <= bus.memory_read_data;
        response_channel <= grant;
      end
    end
  end

  assign bus.full                = full;
  assign bus.empty               = empty;
  assign bus.write_ready         = push_hit;
  assign bus.pop_ready           = pop_hit;
  assign bus.memory_enable       = memory_enable;
  assign bus.memory_write_enable = memory_write_enable;
  assign bus.memory_address      = memory_address;
  assign bus.memory_write_data   = memory_write_data;
  assign bus.response_valid      = response_valid;
  assign bus.response_data       = response_data;
  assign bus.response_channel    = response_channel;

endmodule
